// File: rtl/fir_alu.sv
// fir_alu: pipelined signed Q4.11 add / full-precision multiply unit with fixed latency.
module fir_alu #(
  parameter int N   = 16,
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             sel,
  output logic             out_valid,
  output logic [2*N-1:0]   out,
  output logic             out_sel
);
  logic signed [2*N-1:0] a_ext, b_ext, res_d;
  logic [2*N-1:0] data_q [LAT];
  logic           sel_q  [LAT];
  logic           vld_q  [LAT];
  // Operands are widened to 2N first, so the truncated product equals the full signed product
  always_comb begin
    a_ext = {{N{a[N-1]}}, a};
    b_ext = {{N{b[N-1]}}, b};
    res_d = sel ? a_ext * b_ext : a_ext + b_ext;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= 1'b0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= res_d;
        sel_q[0]  <= sel;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          sel_q[i]  <= sel_q[i-1];
        end
      end
    end
  end
  assign out_valid = vld_q[LAT-1];
  assign out       = data_q[LAT-1];
  assign out_sel   = sel_q[LAT-1];
endmodule

// File: tb/tb_fir_alu.sv
// tb_fir_alu: scoreboard bench for fir_alu; directed steps plus a 64-op alternating stream.
module tb_fir_alu;
  localparam int N = 16;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic sel = 1'b0;
  logic out_valid;
  logic [2*N-1:0] out;
  logic out_sel;
  logic [2*N:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  fir_alu #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out(out), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_valid: out_valid=1 out=%h with no result expected", out);
      end
      if (exp_q.size() != 0) begin
        logic [2*N:0] e;
        e = exp_q.pop_front();
        n_pop++;
        n_cmp++;
        assert ({out_sel, out} === e) else begin
          n_err++;
          $error("FAIL result: got sel=%0b out=%h, want sel=%0b out=%h", out_sel, out, e[2*N], e[2*N-1:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [2*N-1:0] got, input logic [2*N-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic issue(input logic s, input logic [N-1:0] x, input logic [N-1:0] y, input logic [2*N-1:0] e);
    @(negedge clk);
    in_valid = 1'b1; sel = s; a = x; b = y;
    exp_q.push_back({s, e});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; sel = 1'($urandom); a = N'($urandom); b = N'($urandom);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
    longint ex, ey, r;
    ex = longint'($signed(x));
    ey = longint'($signed(y));
    r = s ? ex * ey : ex + ey;
    return r[2*N-1:0];
  endfunction

  initial begin
    int pop0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_sel", 32'(out_sel), 32'd0);
    rst = 1'b0;
    issue(1'b0, 16'h0800, 16'h0400, 32'h00000C00);
    issue(1'b1, 16'h0800, 16'h0400, 32'h00200000);
    issue(1'b1, 16'hF800, 16'h0400, 32'hFFE00000);
    issue(1'b0, 16'hF800, 16'h0400, 32'hFFFFFC00);
    issue(1'b0, 16'h7FFF, 16'h7FFF, 32'h0000FFFE);
    issue(1'b0, 16'h8000, 16'h8000, 32'hFFFF0000);
    issue(1'b1, 16'h8000, 16'h8000, 32'h40000000);
    issue(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
    idle(LAT + 3);
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_hold_out", out, 32'hC0008000);
    chk("bubble_hold_sel", 32'(out_sel), 32'd1);
    chk("directed_drained", 32'(exp_q.size()), 32'd0);
    pop0 = n_pop;
    for (int i = 0; i < 64; i++) begin
      logic [N-1:0] x, y;
      x = N'($urandom);
      y = N'($urandom);
      if (i == 10) begin x = 16'h8000; y = 16'h8000; end
      if (i == 11) begin x = 16'h7FFF; y = 16'h7FFF; end
      issue(1'(i % 2), x, y, model(1'(i % 2), x, y));
    end
    idle(LAT + 3);
    chk("stream_count", 32'(n_pop - pop0), 32'd64);
    @(negedge clk);
    in_valid = 1'b1; sel = 1'b1; a = 16'h0800; b = 16'h0400;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop_reset_valid", 32'(out_valid), 32'd0);
    chk("midop_reset_out", out, 32'd0);
    chk("midop_reset_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; sel = 1'b0; a = 16'h1234; b = 16'h0101;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    idle(LAT + 3);
    chk("rst_input_valid", 32'(out_valid), 32'd0);
    chk("rst_input_out", out, 32'd0);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
